// File: rtl/rr_decoder_arbiter_if.sv
// Request/decoder bus shared between the requesters and rr_decoder_arbiter.
interface rr_decoder_arbiter_if;
  logic [7:0] req;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  // Requester side drives req and observes the decoder controls.
  modport master (
    output req,
    input  sel,
    input  en,
    input  gnt,
    input  busy,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    output sel,
    output en,
    output gnt,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 decoder for eight requesters.
// Owners are separated by one dead GAP cycle. With ARB_TIMEOUT_EN defined a
// hold counter forces release after HOLD_MAX cycles and pulses timeout in
// the following GAP; without it a grant lasts until its request drops.
module rr_decoder_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_decoder_arbiter_if.slave  bus
);

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  // Reject configurations where the counter cannot reach HOLD_MAX.
  if (HOLD_MAX < 1 || ((64'(1) << CNT_W) - 64'(1)) < 64'(HOLD_MAX)) begin : g_bad_cfg
    $error("rr_decoder_arbiter: need HOLD_MAX >= 1 and 2**CNT_W-1 >= HOLD_MAX");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic               en_q, en_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   idx;
  logic               found;

  // First set request after the last owner, ascending with wrap.
  always_comb begin
    win   = last_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = SEL_W'(32'(last_q) + k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      ST_GRANT: begin
        if (!bus.req[sel_q]) begin
          state_d = ST_GAP;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(HOLD_MAX)) begin
          state_d   = ST_GAP;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        // IDLE and GAP both run a fresh search.
        if (bus.req != '0) begin
          state_d = ST_GRANT;
          sel_d   = win;
          last_d  = win;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = CNT_W'(1);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    en_d   = (state_d == ST_GRANT);
    gnt_d  = en_d ? (NREQ'(1) << sel_d) : '0;
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      last_q    <= SEL_W'(NREQ - 1);
      en_q      <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      en_q      <= en_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter for forced release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.sel     = sel_q;
  assign bus.en      = en_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Testbench for rr_decoder_arbiter: fixed vector table, hand-written
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_rr_decoder_arbiter;

  localparam int unsigned HOLD = 4;
  localparam int unsigned CW   = 3;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  rr_decoder_arbiter_if bus ();

  rr_decoder_arbiter #(.HOLD_MAX(HOLD), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: mode 0 idle, 1 owner holds, 2 dead cycle.
  int m_mode, m_sel, m_last, m_run;
  bit m_to;

  function automatic int pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return last;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_last = 7; m_run = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    m_to = 1'b0;
    if (m_mode == 1) begin
      if (!r[m_sel]) m_mode = 2;
      else if (TO_EN && m_run == int'(HOLD)) begin m_mode = 2; m_to = 1'b1; end
      else m_run++;
    end else if (r != 8'h00) begin
      m_sel = pick(r, m_last); m_last = m_sel; m_run = 1; m_mode = 1;
    end else begin
      m_mode = 0;
    end
  endtask

  function automatic logic [13:0] pack(input int sel, input bit en, input bit busy, input bit to);
    logic [7:0] g;
    g = en ? (8'h01 << sel) : 8'h00;
    return {3'(sel), en, g, busy, to};
  endfunction

  function automatic logic [13:0] model_exp();
    return pack(m_sel, m_mode == 1, m_mode != 0, m_to);
  endfunction

  function automatic logic [13:0] dut_out();
    return {bus.sel, bus.en, bus.gnt, bus.busy, bus.timeout};
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got sel=%0d en=%b gnt=%02h busy=%b to=%b, required sel=%0d en=%b gnt=%02h busy=%b to=%b",
               name, $time, got[13:11], got[10], got[9:2], got[1], got[0],
               exp[13:11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Apply r before the next edge, advance the model, sample 1 ns after.
  task automatic cyc(input logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    if (rst_n) model_step(r);
    #1;
  endtask

  // Assert reset with all requests high, then release mid-cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 8'hFF;
    model_reset();
    #1;
    check("reset_async", dut_out(), 14'h0);
    @(posedge clk); #1;
    check("reset_hold", dut_out(), 14'h0);
    #3;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] req;
    int         sel;
    bit         en;
    bit         busy;
    bit         to;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{8'h04, 2, 1, 1, 0};
    tbl[1]  = '{8'h04, 2, 1, 1, 0};
    tbl[2]  = '{8'h04, 2, 1, 1, 0};
    tbl[3]  = '{8'h00, 2, 0, 1, 0};
    tbl[4]  = '{8'h00, 2, 0, 0, 0};
    tbl[5]  = '{8'h21, 5, 1, 1, 0};
    tbl[6]  = '{8'h01, 5, 0, 1, 0};
    tbl[7]  = '{8'h01, 0, 1, 1, 0};
    tbl[8]  = '{8'h20, 0, 0, 1, 0};
    tbl[9]  = '{8'h00, 0, 0, 0, 0};
    tbl[10] = '{8'h01, 0, 1, 1, 0};
    tbl[11] = '{8'h03, 0, 1, 1, 0};
    tbl[12] = '{8'h02, 0, 0, 1, 0};
    tbl[13] = '{8'h02, 1, 1, 1, 0};
    tbl[14] = '{8'h00, 1, 0, 1, 0};
    tbl[15] = '{8'h00, 1, 0, 0, 0};

    bus.req = 8'h00;
    model_reset();
    #2;

    // Reset values and first grant after release.
    do_reset();
    cyc(8'hFF);
    check("first_grant", dut_out(), pack(0, 1, 1, 0));

    // Table of voluntary releases, gaps and round-robin order.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].req);
      check($sformatf("table[%0d]", i), dut_out(), pack(tbl[i].sel, tbl[i].en, tbl[i].busy, tbl[i].to));
    end

    do_reset();
    if (TO_EN) begin
      // Two requesters: forced release alternates owners 0,7,0,7.
      for (int g = 0; g < 4; g++) begin
        for (int c = 0; c < int'(HOLD); c++) begin
          cyc(8'h81);
          check($sformatf("to_fair_g%0d_c%0d", g, c), dut_out(), pack((g % 2) ? 7 : 0, 1, 1, 0));
        end
        cyc(8'h81);
        check($sformatf("to_fair_gap%0d", g), dut_out(), pack((g % 2) ? 7 : 0, 0, 1, 1));
      end
      // Full contention: owners 0..7 then 0.
      do_reset();
      for (int o = 0; o < 9; o++) begin
        for (int c = 0; c < int'(HOLD); c++) begin
          cyc(8'hFF);
          check($sformatf("contend_o%0d_c%0d", o, c), dut_out(), pack(o % 8, 1, 1, 0));
        end
        cyc(8'hFF);
        check($sformatf("contend_gap%0d", o), dut_out(), pack(o % 8, 0, 1, 1));
      end
    end else begin
      // No forced release: a held request keeps the grant indefinitely.
      for (int c = 0; c < 20; c++) begin
        cyc(8'h04);
        check($sformatf("no_to_hold_c%0d", c), dut_out(), pack(2, 1, 1, 0));
      end
    end

    // Asynchronous reset in the middle of a grant to requester 5.
    do_reset();
    cyc(8'h20);
    cyc(8'h20);
    check("pre_async_grant5", dut_out(), pack(5, 1, 1, 0));
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_mid_grant", dut_out(), 14'h0);
    bus.req = 8'h21;
    #2;
    rst_n = 1'b1;
    cyc(8'h21);
    check("after_async_first", dut_out(), pack(0, 1, 1, 0));

    // Random stimulus against the model, with sticky request patterns.
    do_reset();
    begin
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) r = 8'($urandom);
        if ($urandom_range(0, 7) == 0) r = r & 8'($urandom);
        cyc(r);
        check($sformatf("rand[%0d]", i), dut_out(), model_exp());
        vectors++;
        if (!$onehot0(bus.gnt)) begin
          miscompares++;
          $display("FAIL rand_onehot[%0d]: got gnt=%02h, required one-hot or zero", i, bus.gnt);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_decoder_arbiter.md
# rr_decoder_arbiter

Round-robin arbiter that shares one 3-to-8 decoder among eight requesters. Each cycle it picks at most one requester and drives the decoder's select and enable lines. It also provides a registered one-hot grant vector that matches the decoder output. A bounded hold time and a one-cycle dead gap between owners stop any single requester from monopolising the decoded resource and prevent overlapping selects.

## Interface
- HOLD_MAX, 15: maximum consecutive cycles a grant may stay asserted; must be ≥1.
- CNT_W, 4: hold counter width; must satisfy 2^CNT_W − 1 ≥ HOLD_MAX.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- REQ  in  8  request vector; REQ[i]=1 means requester i wants the resource and keeps it while held.
- SEL  out  3  decoder select (S2..S0 order = SEL[2:0]); index of the current owner.
- EN  out  1  decoder enable; high only in GRANT.
- GNT  out  8  one-hot grant; equals 1<<SEL while EN=1, otherwise 0.
- BUSY  out  1  high in GRANT or GAP.
- TIMEOUT  out  1  one-cycle pulse in the GAP cycle that follows a forced release.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner selected, EN=1.
  - GAP: exactly one dead cycle, EN=0, SEL holds the previous owner.
- Round-robin search: start at (LAST+1) mod 8, ascending with wrap; the first set REQ bit wins. LAST is the most recent owner. LAST itself wins again only if it is the sole requester.
- IDLE → GRANT: REQ≠0 at a clock edge. Load SEL=winner, cnt=1, update LAST.
- GRANT:
  - REQ[SEL]=0 → GAP.
  - Otherwise, if cnt==HOLD_MAX and timeout is enabled → GAP with TIMEOUT=1.
  - Otherwise stay in GRANT and cnt++.
- Release of REQ takes priority over timeout in the same cycle. In that case TIMEOUT=0.
- GAP → GRANT if REQ≠0, using a fresh round-robin search. GAP → IDLE if REQ=0.
- Changes to other REQ bits during GRANT have no effect until the next search.
- The counter never wraps. It saturates logically at HOLD_MAX because the transition out of GRANT occurs there.
- Reset values:
  - state=IDLE, SEL=0, EN=0, GNT=0, BUSY=0, TIMEOUT=0, cnt=0.
  - LAST=7, so the first search after reset starts at requester 0.
- Reset mid-operation: assertion clears all outputs immediately, without waiting for a clock edge. Any in-progress grant is dropped with no GAP cycle.

## Timing
- All outputs are registered; there is no combinational path from REQ to any output.
- Grant latency: REQ set before edge n (state IDLE) → EN/GNT/SEL valid after edge n (1 cycle).
- Release latency: REQ[SEL] cleared before edge n → EN=0 after edge n. After edge n+1 the next owner is granted if one exists.
- Owner-to-owner turnaround: exactly 1 cycle with EN=0.
- Maximum EN-high run per grant: HOLD_MAX cycles (timeout enabled).
- TIMEOUT is high for exactly the single GAP cycle that follows a forced release.
- The first clock edge after RST_N deasserts is a normal IDLE evaluation.

## Configuration
- ARB_TIMEOUT_EN defined:
  - The hold counter is compiled in.
  - Grants are forcibly released after HOLD_MAX cycles and TIMEOUT pulses.
- ARB_TIMEOUT_EN undefined:
  - The counter logic is removed and TIMEOUT is tied to 0.
  - A grant persists until its REQ drops.
  - HOLD_MAX and CNT_W are accepted but ignored.

## Test plan
All scenarios use HOLD_MAX=4 with ARB_TIMEOUT_EN defined unless noted.
- **Reset values:** hold RST_N=0 with REQ=8'hFF → SEL=0, EN=0, GNT=0, BUSY=0, TIMEOUT=0. Release reset → next edge SEL=0, EN=1, GNT=8'h01.
- **Single voluntary release:** REQ=8'h04 for 3 cycles, then 0 → EN high 3 cycles with SEL=2, GNT=8'h04. Then one GAP cycle (BUSY=1, EN=0, TIMEOUT=0), then IDLE (BUSY=0).
- **Timeout fairness:** REQ=8'h81 held → grants alternate 0,7,0,7. Each grant has EN high exactly 4 cycles, followed by a 1-cycle GAP with TIMEOUT=1.
- **Full contention:** REQ=8'hFF held → owners in order 0,1,…,7,0. SEL never repeats consecutively, and GNT is always one-hot or zero.
- **Asynchronous reset mid-grant:** assert RST_N=0 mid-cycle during a grant of requester 5 → EN/GNT clear before the next edge. After release with REQ=8'h21, the first grant goes to 0, not 5.
- **Timeout compiled out:** ARB_TIMEOUT_EN undefined, REQ=8'h04 held 20 cycles → EN high for all 20 cycles and TIMEOUT stays 0 throughout.
